normalize_ff_stage: RTL and testbench
=====================================

# normalize_ff_stage

Registered normalization/packing stage at the back end of the Goldschmidt divider datapath. Takes the sign, biased exponent and raw 48-bit fixed-point mantissa product from the iteration multiplier. Normalizes the product, optionally rounds it, handles exponent overflow and underflow, and registers an IEEE-754 single-precision word. Module name: `normalize_ff_stage`.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock; the only clock.
- `clr_b`  input  1  synchronous, active-high clear. 1 on a rising edge clears the output register. The port name is kept for codebase compatibility; the polarity is high.
- `S_in`  input  1  result sign.
- `E_in`  input  8  biased exponent (bias 127) associated with a product value in [1,2).
- `P_in`  input  48  unsigned product, fixed point 2.46: bits 47:46 are integer bits, bits 45:0 are fraction.
- `P_normalized`  output  32  registered IEEE-754 single: {sign, exp[7:0], frac[22:0]}.

## Operation
- Special inputs, in priority order:
  - `E_in`==0 or `P_in`==0 → signed zero {S_in, 31'b0}.
  - `E_in`==255 → signed infinity {S_in, 8'hFF, 23'b0}.
- Normalization:
  - Find leading one at bit k (47..0) of `P_in` with a priority encoder / leading-zero count.
  - Unrounded exponent: Eu = E_in + (k − 46), computed as a signed 10-bit value.
  - k=47: frac = P_in[46:24], guard = P_in[23], sticky = |P_in[22:0].
  - k=46: frac = P_in[45:23], guard = P_in[22], sticky = |P_in[21:0].
  - k<46: left-shift `P_in` by (46−k) first, then apply the k=46 rule.
- Rounding: see Configuration.
  - Round-up increments frac.
  - A carry out of frac sets frac=0 and Eu=Eu+1.
- Exponent range, applied after rounding:
  - Eu ≥ 255 → signed infinity.
  - Eu ≤ 0 → signed zero (flush; no subnormals).
  - Otherwise exp = Eu[7:0].
- Sign always passes through unchanged, including for zero and infinity results.

## Timing
- Logic from inputs to the register is purely combinational. One register stage.
- Latency is 1 cycle. Inputs sampled at rising edge N appear on `P_normalized` after edge N.
- Throughput is one result per cycle. No handshake; a new input is accepted every cycle.
- `clr_b`=1 at an edge sets `P_normalized`=32'h00000000 and ignores the inputs that cycle. Clear has priority.
- After clear deasserts, the next edge loads from the inputs normally.
- Before the first clear, the output is unspecified (X in simulation).
- X or undriven inputs while clear is asserted must not propagate to the output.

## Configuration
- `NORMALIZE_FF_ROUND_EN` defined:
  - Round-to-nearest-even.
  - Round up when guard & (sticky | frac[0]).
- Not defined:
  - Truncation; guard and sticky are ignored.
  - The rounding incrementer is not synthesized.
- Both builds give identical results when guard=0.

## Test plan
- Clear: assert `clr_b`=1 for 2 edges with arbitrary inputs → `P_normalized`=32'h00000000 throughout.
- Unity: S=0, E=127, P=48'h400000000000, clear released → 32'h3F800000 one edge later.
- Overflowing integer part: S=0, E=127, P=48'hE10000000000 (3.515625) → 32'h40610000 on the next edge. Back-to-back with the previous vector; each result appears exactly one cycle after its input.
- Sub-unity product: S=1, E=127, P=48'h200000000000 (0.5) → 32'hBF000000.
- Rounding with S=0, E=127, P=48'h7FFFFFFFFFFF:
  - with `NORMALIZE_FF_ROUND_EN` → 32'h40000000 (mantissa carry bumps exponent);
  - without it → 32'h3FFFFFFF.
- Range limits:
  - E=254, P=48'h800000000000 → 32'h7F800000 (overflow to infinity).
  - E=1, P=48'h200000000000 → 32'h00000000 (underflow flush).
  - E=0 with any P → signed zero.

Source files
------------

// File: rtl/normalize_ff_stage.sv
// Normalizes a 2.46 mantissa product into a registered IEEE-754 single word (1-cycle latency, no backpressure).
// Define NORMALIZE_FF_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module normalize_ff_stage (
  input  logic        clk,
  input  logic        clr_b,
  input  logic        S_in,
  input  logic [7:0]  E_in,
  input  logic [47:0] P_in,
  output logic [31:0] P_normalized
);

  logic [5:0]        lzc;
  logic [47:0]       p_sh;
  logic [22:0]       frac;
  logic signed [9:0] eu;
  logic [22:0]       frac_rnd;
  logic signed [9:0] eu_rnd;
  logic [31:0]       result;
  logic              unused_bits;

  // Leading-zero count: the highest set bit wins because it is visited last.
  always_comb begin
    lzc = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (P_in[i]) lzc = 6'(47 - i);
    end
  end

  // Shifting the leading one up to bit 47 folds the k=47, k=46 and k<46 cases together.
  assign p_sh = P_in << lzc;
  assign frac = p_sh[46:24];
  assign eu   = signed'({2'b00, E_in}) + 10'sd1 - signed'({4'b0000, lzc});

`ifdef NORMALIZE_FF_ROUND_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_sum;

  assign guard    = p_sh[23];
  assign sticky   = |p_sh[22:0];
  assign round_up = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {23'd0, round_up};
  // A carry out means the fraction wrapped to zero and the value doubled.
  assign frac_rnd = frac_sum[22:0];
  assign eu_rnd   = eu + (frac_sum[23] ? 10'sd1 : 10'sd0);
  assign unused_bits = p_sh[47];
`else
  assign frac_rnd = frac;
  assign eu_rnd   = eu;
  assign unused_bits = ^{p_sh[47], p_sh[23:0]};
`endif

  always_comb begin
    result = {S_in, eu_rnd[7:0], frac_rnd};
    if (E_in == 8'd0 || P_in == 48'd0) begin
      result = {S_in, 31'd0};
    end else if (E_in == 8'hFF) begin
      result = {S_in, 8'hFF, 23'd0};
    end else if (eu_rnd >= 10'sd255) begin
      result = {S_in, 8'hFF, 23'd0};
    end else if (eu_rnd <= 10'sd0) begin
      result = {S_in, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (clr_b) begin
      P_normalized <= 32'h0000_0000;
    end else begin
      P_normalized <= result;
    end
  end

endmodule

// File: tb/tb_normalize_ff_stage.sv
// Directed and sweep checks of normalize_ff_stage against a value-level float model.
module tb_normalize_ff_stage;

  logic        clk;
  logic        clr_b;
  logic        S_in;
  logic [7:0]  E_in;
  logic [47:0] P_in;
  logic [31:0] P_normalized;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q;
  bit          exp_vld = 0;

  normalize_ff_stage dut (
    .clk(clk),
    .clr_b(clr_b),
    .S_in(S_in),
    .E_in(E_in),
    .P_in(P_in),
    .P_normalized(P_normalized)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value is p * 2^(e-127-46); keep a 24-bit mantissa and round on the remainder.
  function automatic logic [31:0] model(input bit s, input bit [7:0] e, input bit [47:0] p);
    logic [63:0] m;
    logic [63:0] rem;
    logic [63:0] half;
    int          msb;
    int          ex;
    if (e == 8'd0 || p == 48'd0) return {s, 31'd0};
    if (e == 8'hFF) return {s, 8'hFF, 23'd0};
    msb = 47;
    while (p[msb] == 1'b0) msb--;
    ex = int'(e) + msb - 46;
    if (msb >= 23) begin
      m    = 64'(p) >> (msb - 23);
      rem  = 64'(p) & ((64'd1 << (msb - 23)) - 64'd1);
      half = (msb > 23) ? (64'd1 << (msb - 24)) : 64'd0;
    end else begin
      m    = 64'(p) << (23 - msb);
      rem  = 64'd0;
      half = 64'd0;
    end
`ifdef NORMALIZE_FF_ROUND_EN
    if (msb > 23 && (rem > half || (rem == half && m[0]))) m = m + 64'd1;
`endif
    if (m == (64'd1 << 24)) begin
      m  = 64'd1 << 23;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    if (ex <= 0) return {s, 31'd0};
    return {s, ex[7:0], m[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    if (clr_b) exp_q = 32'h0;
    else       exp_q = model(S_in, E_in, P_in);
    exp_vld = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_vld) check("model_cmp", P_normalized, exp_q);
  end

  // Called just after a rising edge: drive, take one edge, check the literal.
  task automatic step(input bit c, input bit s, input bit [7:0] e, input bit [47:0] p,
                      input string name, input logic [31:0] expv);
    clr_b = c;
    S_in  = s;
    E_in  = e;
    P_in  = p;
    @(posedge clk);
    #1;
    check(name, P_normalized, expv);
  endtask

  initial begin
    clr_b = 1'b1;
    S_in  = 1'bx;
    E_in  = 8'hxx;
    P_in  = 48'hx;
    @(posedge clk);
    #1;
    check("clear_0", P_normalized, 32'h0000_0000);
    step(1'b1, 1'b1, 8'hFF, 48'hFFFF_FFFF_FFFF, "clear_1", 32'h0000_0000);

    step(1'b0, 1'b0, 8'd127, 48'h4000_0000_0000, "unity",      32'h3F80_0000);
    step(1'b0, 1'b0, 8'd127, 48'hE100_0000_0000, "int_ovf",    32'h4061_0000);
    step(1'b0, 1'b1, 8'd127, 48'h2000_0000_0000, "half_neg",   32'hBF00_0000);
`ifdef NORMALIZE_FF_ROUND_EN
    step(1'b0, 1'b0, 8'd127, 48'h7FFF_FFFF_FFFF, "round_carry", 32'h4000_0000);
    step(1'b0, 1'b0, 8'd127, 48'h4000_00C0_0000, "tie_odd",     32'h3F80_0002);
    step(1'b0, 1'b0, 8'd253, 48'hFFFF_FFFF_FFFF, "round_inf",   32'h7F80_0000);
`else
    step(1'b0, 1'b0, 8'd127, 48'h7FFF_FFFF_FFFF, "round_carry", 32'h3FFF_FFFF);
    step(1'b0, 1'b0, 8'd127, 48'h4000_00C0_0000, "tie_odd",     32'h3F80_0001);
    step(1'b0, 1'b0, 8'd253, 48'hFFFF_FFFF_FFFF, "round_inf",   32'h7F7F_FFFF);
`endif
    step(1'b0, 1'b0, 8'd127, 48'h4000_0040_0000, "tie_even",   32'h3F80_0000);
    step(1'b0, 1'b0, 8'd254, 48'h8000_0000_0000, "ovf_inf",    32'h7F80_0000);
    step(1'b0, 1'b0, 8'd1,   48'h2000_0000_0000, "udf_flush",  32'h0000_0000);
    step(1'b0, 1'b1, 8'd0,   48'h1234_5678_9ABC, "e_zero",     32'h8000_0000);
    step(1'b0, 1'b1, 8'd100, 48'h0,              "p_zero",     32'h8000_0000);
    step(1'b0, 1'b1, 8'd255, 48'h4000_0000_0000, "e_inf",      32'hFF80_0000);
    step(1'b0, 1'b0, 8'd200, 48'h1,              "p_one",      32'h4D00_0000);
    step(1'b1, 1'b0, 8'd127, 48'h4000_0000_0000, "clear_mid",  32'h0000_0000);
    step(1'b0, 1'b1, 8'd127, 48'h4000_0000_0000, "after_clr",  32'hBF80_0000);

    // Sweep: leading-one positions and exponents across the range, checked by the model.
    for (int i = 0; i < 60; i++) begin
      clr_b = 1'b0;
      S_in  = 1'($urandom_range(0, 1));
      E_in  = 8'($urandom_range(0, 255));
      P_in  = {$urandom(), $urandom()} >> $urandom_range(0, 47);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
